// File: rtl/cordic_ln_if.sv
// Sample stream bundle for the natural-log unit: operand in, ln(x) out.
//
// Stream semantics: valid-only tagging, no ready and no backpressure. A word
// is transferred on every rising clk edge where its valid flag is 1; the
// data lines are ignored whenever valid is 0. The producer may assert valid
// on consecutive cycles, and the consumer must accept every tagged word.
interface cordic_ln_if;
   logic [31:0] iData;       // signed Q16.16 operand x
   logic        pre_vaild;   // iData carries a sample this cycle
   logic [31:0] In;          // signed Q16.16 ln(x)
   logic        post_vaild;  // In carries a result this cycle

   // Source of operands / sink of results.
   modport master (
      output iData,
      output pre_vaild,
      input  In,
      input  post_vaild
   );

   // The log unit itself.
   modport slave (
      input  iData,
      input  pre_vaild,
      output In,
      output post_vaild
   );
endinterface

// File: rtl/cordic_ln.sv
// Pipelined ln(x) using hyperbolic CORDIC in vectoring mode.
// ln(x) = 2*atanh((x-1)/(x+1)); seed X=x+1, Y=x-1, Z=0 and drive Y to zero.
// One sample per clock, fixed latency PIPELINE+2 register stages:
// seed register, PIPELINE micro-rotation registers, output register.
module cordic_ln #(
   parameter int PIPELINE = 16   // micro-rotation stages, 1..16
) (
   input  logic        clk,
   input  logic        rst_n,
   cordic_ln_if.slave  bus
);

   // 34-bit datapath leaves headroom above Q16.16 for x+1 and the sums.
   localparam int W = 34;
   localparam logic signed [W-1:0] ONE = 34'sd65536;

   // Shift index for rotation stage k (1-based); 4 and 13 repeat so the
   // hyperbolic iteration converges.
   function automatic int seq_f(input int k);
      case (k)
         1:       seq_f = 1;
         2:       seq_f = 2;
         3:       seq_f = 3;
         4:       seq_f = 4;
         5:       seq_f = 4;
         6:       seq_f = 5;
         7:       seq_f = 6;
         8:       seq_f = 7;
         9:       seq_f = 8;
         10:      seq_f = 9;
         11:      seq_f = 10;
         12:      seq_f = 11;
         13:      seq_f = 12;
         14:      seq_f = 13;
         15:      seq_f = 13;
         default: seq_f = 14;
      endcase
   endfunction

   // round(atanh(2^-s) * 65536)
   function automatic logic signed [W-1:0] atanh_f(input int s);
      case (s)
         1:       atanh_f = 34'sd35999;
         2:       atanh_f = 34'sd16739;
         3:       atanh_f = 34'sd8235;
         4:       atanh_f = 34'sd4101;
         5:       atanh_f = 34'sd2049;
         6:       atanh_f = 34'sd1024;
         7:       atanh_f = 34'sd512;
         8:       atanh_f = 34'sd256;
         9:       atanh_f = 34'sd128;
         10:      atanh_f = 34'sd64;
         11:      atanh_f = 34'sd32;
         12:      atanh_f = 34'sd16;
         13:      atanh_f = 34'sd8;
         default: atanh_f = 34'sd4;
      endcase
   endfunction

   // Index 0 is the seed register, index k the output of rotation stage k.
   logic signed [W-1:0] x_q [0:PIPELINE];
   logic signed [W-1:0] y_q [0:PIPELINE];
   logic signed [W-1:0] z_q [0:PIPELINE];
   logic signed [W-1:0] x_d [0:PIPELINE];
   logic signed [W-1:0] y_d [0:PIPELINE];
   logic signed [W-1:0] z_d [0:PIPELINE];

   // Valid tag travels alongside the data; bit PIPELINE+1 lines up with In.
   logic [PIPELINE+1:0] vld_q, vld_d;
   logic [31:0]         in_q,  in_d;

   logic signed [W-1:0] x_ext;
   assign x_ext = $signed({{(W-32){bus.iData[31]}}, bus.iData});

   // Seed, micro-rotations and output scaling, all as next-state values.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      x_d[0] = x_ext + ONE;
      y_d[0] = x_ext - ONE;
      z_d[0] = '0;
      for (int k = 1; k <= PIPELINE; k++) begin
         if (!y_q[k-1][W-1]) begin
            x_d[k] = x_q[k-1] - (y_q[k-1] >>> seq_f(k));
            y_d[k] = y_q[k-1] - (x_q[k-1] >>> seq_f(k));
            z_d[k] = z_q[k-1] + atanh_f(seq_f(k));
         end else begin
            x_d[k] = x_q[k-1] + (y_q[k-1] >>> seq_f(k));
            y_d[k] = y_q[k-1] + (x_q[k-1] >>> seq_f(k));
            z_d[k] = z_q[k-1] - atanh_f(seq_f(k));
         end
      end
      // ln(x) = 2*Z, truncated to the 32-bit output word.
      in_d  = {z_q[PIPELINE][30:0], 1'b0};
      vld_d = {vld_q[PIPELINE:0], bus.pre_vaild};
   end

   // Pipeline registers; synchronous reset flushes every in-flight sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q   <= '{default: '0};
         y_q   <= '{default: '0};
         z_q   <= '{default: '0};
         vld_q <= '0;
         in_q  <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         z_q   <= z_d;
         vld_q <= vld_d;
         in_q  <= in_d;
      end
   end

   assign bus.In         = in_q;
   assign bus.post_vaild = vld_q[PIPELINE+1];

   // Final-stage X/Y and the Z bits above the output word are not needed.
   logic unused_bits;
   assign unused_bits = ^{x_q[PIPELINE], y_q[PIPELINE], z_q[PIPELINE][W-1:31]};

endmodule

// File: tb/tb_cordic_ln.sv
// Bench for cordic_ln: a PIPELINE=16 and a PIPELINE=8 instance share the
// same stimulus; a scoreboard holds the expected ln(x) and arrival cycle.
module tb_cordic_ln;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_ln_if bus16();
  cordic_ln_if bus8();

  cordic_ln #(.PIPELINE(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  cordic_ln #(.PIPELINE(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // ---------------- scoreboard ----------------
  typedef struct {
    int dut;     // 0: PIPELINE=16, 1: PIPELINE=8
    int exp_v;   // expected ln(x) in Q16.16
    int tol;     // allowed absolute error in LSB
    int due;     // cycle count at which the result must be visible
  } item_t;
  item_t exp_q[$];

  typedef struct {
    logic [31:0] x;
    int          exp_v;
    int          tol;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference: round(ln(x) * 65536) in real arithmetic.
  function automatic int ref_ln(input logic [31:0] x);
    real r;
    r = $ln(real'($signed(x)) / 65536.0) * 65536.0;
    return int'(r);
  endfunction

  function automatic int find_first(input int d);
    foreach (exp_q[i]) if (exp_q[i].dut == d) return i;
    return -1;
  endfunction

  task automatic check(input string name, input int got, input int exp_v, input int tol);
    checks++;
    if (got - exp_v > tol || exp_v - got > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at cycle %0d", name, got, exp_v, tol, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] x, input logic v, input int exp_v, input int tol);
    @(negedge clk);
    bus16.iData = x;  bus16.pre_vaild = v;
    bus8.iData  = x;  bus8.pre_vaild  = v;
    if (v) begin
      exp_q.push_back('{dut: 0, exp_v: exp_v,     tol: tol,  due: cyc + 18});
      exp_q.push_back('{dut: 1, exp_v: ref_ln(x), tol: 2048, due: cyc + 10});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'd0, 1'b0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic  v;
    int    got;
    int    idx;
    string nm;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        v   = (d == 1) ? bus8.post_vaild : bus16.post_vaild;
        got = (d == 1) ? $signed(bus8.In) : $signed(bus16.In);
        nm  = (d == 1) ? "p8" : "p16";
        idx = find_first(d);
        while (idx >= 0 && exp_q[idx].due < cyc) begin
          checks++; errors++;
          $display("FAIL %s_late: post_vaild never rose, expected due at cycle %0d", nm, exp_q[idx].due);
          exp_q.delete(idx);
          idx = find_first(d);
        end
        if (v) begin
          if (idx >= 0 && exp_q[idx].due == cyc) begin
            check({nm, "_ln"}, got, exp_q[idx].exp_v, exp_q[idx].tol);
            exp_q.delete(idx);
          end else begin
            checks++; errors++;
            $display("FAIL %s_stray: post_vaild=1 with In=%0d, expected post_vaild=0 at cycle %0d", nm, got, cyc);
          end
        end else if (idx >= 0 && exp_q[idx].due == cyc) begin
          checks++; errors++;
          $display("FAIL %s_missing: post_vaild=0, expected 1 at cycle %0d", nm, cyc);
          exp_q.delete(idx);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  vec_t vecs[11];

  initial begin
    logic [31:0] x;
    logic        v;

    vecs[0]  = '{32'd32768,  -45426, 16};
    vecs[1]  = '{32'd21845,  -72000, 16};
    vecs[2]  = '{32'd16384,  -90852, 16};
    vecs[3]  = '{32'd13107, -105478, 16};
    vecs[4]  = '{32'd131072,  45426, 16};
    vecs[5]  = '{32'd196608,  71999, 16};
    vecs[6]  = '{32'd262144,  90852, 16};
    vecs[7]  = '{32'd393216, 117424, 16};
    vecs[8]  = '{32'd458752, 127527, 16};
    vecs[9]  = '{32'd524288, 136278, 16};
    // x = 1.0: truncation in the last micro-rotations leaves a few LSB.
    vecs[10] = '{32'd65536,       0,  4};

    bus16.iData = '0; bus16.pre_vaild = 1'b0;
    bus8.iData  = '0; bus8.pre_vaild  = 1'b0;

    // Reset state.
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_in16",  $signed(bus16.In), 0, 0);
    check("rst_pv16",  int'(bus16.post_vaild), 0, 0);
    check("rst_in8",   $signed(bus8.In), 0, 0);
    check("rst_pv8",   int'(bus8.post_vaild), 0, 0);
    rst_n = 1'b1;
    idle(25);

    // Burst of fractional operands.
    for (int i = 0; i < 5; i++) step(vecs[i].x, 1'b1, vecs[i].exp_v, vecs[i].tol);
    idle(20);
    // Burst of integer operands after an idle gap.
    for (int i = 5; i < 10; i++) step(vecs[i].x, 1'b1, vecs[i].exp_v, vecs[i].tol);
    idle(22);
    // Single x = 1.0 sample.
    step(vecs[10].x, 1'b1, vecs[10].exp_v, vecs[10].tol);
    idle(22);

    // Random operands across the accurate range with random valid gaps.
    for (int i = 0; i < 80; i++) begin
      v = 1'($urandom_range(0, 3) != 0);
      x = 32'($urandom_range(8192, 524288));
      step(x, v, ref_ln(x), 16);
    end
    idle(22);

    // Out-of-range operands: only the valid timing is specified.
    step(32'hFFFF_0000, 1'b1, 0, 32'h7FFF_FFFF);
    step(32'd0,         1'b1, 0, 32'h7FFF_FFFF);
    exp_q.delete();
    step(32'hFFFF_0000, 1'b1, 0, 0);
    begin
      // Rebuild entries with unbounded tolerance for the last sample.
      exp_q.delete();
      exp_q.push_back('{dut: 0, exp_v: 0, tol: 32'h7FFF_FFFF, due: cyc - 2 + 18});
      exp_q.push_back('{dut: 1, exp_v: 0, tol: 32'h7FFF_FFFF, due: cyc - 2 + 10});
      exp_q.push_back('{dut: 0, exp_v: 0, tol: 32'h7FFF_FFFF, due: cyc - 1 + 18});
      exp_q.push_back('{dut: 1, exp_v: 0, tol: 32'h7FFF_FFFF, due: cyc - 1 + 10});
      exp_q.push_back('{dut: 0, exp_v: 0, tol: 32'h7FFF_FFFF, due: cyc + 18});
      exp_q.push_back('{dut: 1, exp_v: 0, tol: 32'h7FFF_FFFF, due: cyc + 10});
    end
    idle(22);

    // Reset while a burst is in flight: nothing stale may emerge.
    for (int i = 0; i < 5; i++) step(vecs[i + 5].x, 1'b1, vecs[i + 5].exp_v, 16);
    idle(4);
    @(negedge clk);
    rst_n = 1'b0;
    bus16.pre_vaild = 1'b0; bus8.pre_vaild = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_pv16", int'(bus16.post_vaild), 0, 0);
    check("midrst_in16", $signed(bus16.In), 0, 0);
    check("midrst_pv8",  int'(bus8.post_vaild), 0, 0);
    check("midrst_in8",  $signed(bus8.In), 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(30);

    // Recovery: the first burst again after reset.
    for (int i = 0; i < 5; i++) step(vecs[i].x, 1'b1, vecs[i].exp_v, vecs[i].tol);
    idle(25);

    foreach (exp_q[i]) begin
      checks++; errors++;
      $display("FAIL leftover_p%0d: result due at cycle %0d never appeared, expected post_vaild=1",
               (exp_q[i].dut == 1) ? 8 : 16, exp_q[i].due);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
